// File: rtl/fxp_mul_scheduler.sv
// Round-robin front end that time-shares one Q16.16 sign-magnitude multiplier between
// N_REQ requesters. Each operation runs to completion before the next grant.
module fxp_mul_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_a,
  input  logic [N_REQ*DATA_W-1:0]    req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          mul_a,
  output logic [DATA_W-1:0]          mul_b,
  input  logic [DATA_W-1:0]          mul_s,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DATA_W-1:0]          resp_data,
  output logic [$clog2(N_REQ)-1:0]   resp_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           op_count
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned LAT_W = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [DATA_W-1:0]   a_arr [N_REQ];
  logic [DATA_W-1:0]   b_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : gen_unpack
    assign a_arr[g] = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g] = req_b[g*DATA_W +: DATA_W];
  end

  // Rotate valids so bit 0 is the pointer position, pick the lowest set bit, rotate back.
  logic [2*N_REQ-1:0]  dbl;
  logic [N_REQ-1:0]    rot;
  logic [ID_W-1:0]     off;
  logic [ID_W:0]       sum;
  logic [ID_W-1:0]     grant;
  logic                any_valid;

  always_comb begin
    dbl       = {req_valid, req_valid} >> ptr_q;
    rot       = dbl[N_REQ-1:0];
    any_valid = |req_valid;
    off       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
    grant = sum[ID_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    count_d   = count_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          req_ready = N_REQ'(1) << grant;
          a_d       = a_arr[grant];
          b_d       = b_arr[grant];
          id_d      = grant;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == LAT_W'(MUL_LAT)) begin
          res_d   = mul_s;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
          ptr_d   = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          if (count_q != '1) count_d = count_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      count_q <= count_d;
    end
  end

  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign resp_valid = (state_q == StResp);
  assign resp_data  = res_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != StIdle);
  assign op_count   = count_q;

endmodule

// File: tb/tb_fxp_mul_scheduler.sv
// Self-checking bench: one zero-latency and one 3-cycle-latency scheduler, each driving a
// behavioural sign-magnitude multiplier; grants and products come from a round-robin model.
module tb_fxp_mul_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  // Instance with MUL_LAT=0
  logic           rst0, rr0, rv0, busy0;
  logic [N-1:0]   v0, rdy0;
  logic [N*W-1:0] a0, b0;
  logic [W-1:0]   ma0, mb0, ms0, rd0;
  logic [1:0]     rid0;
  logic [15:0]    cnt0;

  // Instance with MUL_LAT=3
  logic           rst3, rr3, rv3, busy3;
  logic [N-1:0]   v3, rdy3;
  logic [N*W-1:0] a3, b3;
  logic [W-1:0]   ma3, mb3, ms3, rd3;
  logic [1:0]     rid3;
  logic [15:0]    cnt3;
  logic [W-1:0]   pipe [3];

  function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] y);
    logic [61:0] p;
    p = {31'b0, x[30:0]} * {31'b0, y[30:0]};
    return {x[31] ^ y[31], p[46:16]};
  endfunction

  assign ms0 = qmul(ma0, mb0);

  always @(posedge clk) begin
    pipe[0] <= qmul(ma3, mb3);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign ms3 = pipe[2];

  fxp_mul_scheduler #(.N_REQ(4), .DATA_W(32), .MUL_LAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(v0), .req_a(a0), .req_b(b0), .req_ready(rdy0),
    .mul_a(ma0), .mul_b(mb0), .mul_s(ms0), .resp_valid(rv0), .resp_ready(rr0),
    .resp_data(rd0), .resp_id(rid0), .busy(busy0), .op_count(cnt0)
  );

  fxp_mul_scheduler #(.N_REQ(4), .DATA_W(32), .MUL_LAT(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_a(a3), .req_b(b3), .req_ready(rdy3),
    .mul_a(ma3), .mul_b(mb3), .mul_s(ms3), .resp_valid(rv3), .resp_ready(rr3),
    .resp_data(rd3), .resp_id(rid3), .busy(busy3), .op_count(cnt3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first valid index searching circularly from the pointer.
  int mptr   = 0;
  int mcount = 0;

  function automatic int mgrant(input logic [3:0] v, input int ptr);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (ptr + i) % 4;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // One full operation on dut0 with resp_ready high; returns the acceptance cycle.
  task automatic op0(input logic [3:0] vmask, output int gcyc);
    int g, n;
    logic [31:0] expd;
    v0 = vmask;
    g  = mgrant(vmask, mptr);
    #1;
    chk("grant", 32'(rdy0), 32'(1 << g));
    expd = qmul(a0[g*32 +: 32], b0[g*32 +: 32]);
    gcyc = cyc;
    step();
    n = 1;
    while (!rv0 && n < 20) begin
      step();
      n++;
    end
    chk("latency", 32'(n), 32'd2);
    chk("data", rd0, expd);
    chk("id", 32'(rid0), 32'(g));
    step();
    mptr = (g + 1) % 4;
    mcount++;
    chk("count", 32'(cnt0), 32'(mcount));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int gc [5];
    int g, n;
    logic [31:0] hd, expd, sa, sb;
    logic [1:0]  hid;
    logic [3:0]  mask;
    logic        seen;

    rst0 = 1'b1; rst3 = 1'b1; rr0 = 1'b1; rr3 = 1'b1;
    v0 = '0; v3 = '0; a0 = '0; b0 = '0; a3 = '0; b3 = '0;
    step(); step();
    rst0 = 1'b0; rst3 = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_mul_a", ma0, 32'd0);
    chk("rst_mul_b", mb0, 32'd0);
    chk("rst_valid", 32'(rv0), 32'd0);
    chk("rst_data", rd0, 32'd0);
    chk("rst_id", 32'(rid0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count", 32'(cnt0), 32'd0);

    // 1.5 * 3.25 on requester 0
    a0[0 +: 32] = 32'h0001_8000;
    b0[0 +: 32] = 32'h0003_4000;
    op0(4'b0001, gc[0]);
    chk("pos_product", rd0, 32'h0004_E000);

    // 1.5 * -3.25 on requester 1
    a0[32 +: 32] = 32'h0001_8000;
    b0[32 +: 32] = 32'h8003_4000;
    op0(4'b0010, gc[0]);
    chk("neg_product", rd0, 32'h8004_E000);
    chk("neg_id", 32'(rid0), 32'd1);

    v0 = '0;
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    mptr = 0;
    mcount = 0;

    // All four requesters held valid: 0,1,2,3,0 with one grant every 3 cycles
    for (int i = 0; i < 4; i++) begin
      a0[i*32 +: 32] = $urandom;
      b0[i*32 +: 32] = $urandom;
    end
    for (int k = 0; k < 5; k++) begin
      op0(4'hF, gc[k]);
      chk("rr_id", 32'(rid0), 32'(k % 4));
      if (k > 0) chk("issue_period", 32'(gc[k] - gc[k-1]), 32'd3);
    end

    op0(4'b0100, gc[0]);
    op0(4'b1010, gc[0]);
    chk("skip_to_3", 32'(rid0), 32'd3);
    op0(4'b1010, gc[0]);
    chk("wrap_to_1", 32'(rid0), 32'd1);

    // Back-pressure: response held, no new grant while stalled
    rr0 = 1'b0;
    v0  = 4'hF;
    g   = mgrant(v0, mptr);
    expd = qmul(a0[g*32 +: 32], b0[g*32 +: 32]);
    #1;
    step();
    n = 1;
    while (!rv0 && n < 20) begin
      step();
      n++;
    end
    chk("stall_latency", 32'(n), 32'd2);
    hd  = rd0;
    hid = rid0;
    chk("stall_data", hd, expd);
    chk("stall_id", 32'(hid), 32'(g));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", 32'(rv0), 32'd1);
      chk("stall_hold_data", rd0, hd);
      chk("stall_hold_id", 32'(rid0), 32'(hid));
      chk("stall_no_grant", 32'(rdy0), 32'd0);
    end
    rr0 = 1'b1;
    step();
    mptr = (g + 1) % 4;
    mcount++;
    chk("stall_count", 32'(cnt0), 32'(mcount));
    chk("stall_idle", 32'(busy0), 32'd0);
    chk("stall_next_grant", 32'(rdy0), 32'(1 << mgrant(v0, mptr)));

    // Randomised traffic
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 4; i++) begin
        a0[i*32 +: 32] = $urandom;
        b0[i*32 +: 32] = $urandom;
      end
      mask = 4'($urandom_range(1, 15));
      op0(mask, gc[0]);
    end
    v0 = '0;

    // Latency 3: operands stable across all BUSY cycles
    sa = $urandom;
    sb = $urandom;
    a3[64 +: 32] = sa;
    b3[64 +: 32] = sb;
    v3 = 4'b0100;
    #1;
    chk("l3_grant", 32'(rdy3), 32'b0100);
    step();
    v3 = '0;
    n = 1;
    while (!rv3 && n < 20) begin
      chk("l3_mul_a_stable", ma3, sa);
      chk("l3_mul_b_stable", mb3, sb);
      step();
      n++;
    end
    chk("l3_latency", 32'(n), 32'd5);
    chk("l3_data", rd3, qmul(sa, sb));
    chk("l3_id", 32'(rid3), 32'd2);
    step();

    // Reset in the second BUSY cycle aborts the operation
    a3[96 +: 32] = $urandom;
    b3[96 +: 32] = $urandom;
    v3 = 4'b1000;
    #1;
    chk("abort_grant", 32'(rdy3), 32'b1000);
    step();
    v3 = '0;
    step();
    chk("abort_busy_before", 32'(busy3), 32'd1);
    rst3 = 1'b1;
    step();
    chk("abort_ready", 32'(rdy3), 32'd0);
    chk("abort_mul_a", ma3, 32'd0);
    chk("abort_mul_b", mb3, 32'd0);
    chk("abort_valid", 32'(rv3), 32'd0);
    chk("abort_data", rd3, 32'd0);
    chk("abort_id", 32'(rid3), 32'd0);
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_count", 32'(cnt3), 32'd0);
    rst3 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rv3) seen = 1'b1;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    v3 = 4'b1010;
    #1;
    chk("post_reset_grant", 32'(rdy3), 32'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
